// File: rtl/intt_lane_if.sv
// Operand/result bundle between the INTT controller and one inverse-NTT lane.
interface intt_lane_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    // Valid-only handshake: the lane accepts every cycle in which in_valid is
    // high and raises out_valid exactly one cycle later; there is no ready.
    logic                  in_valid;
    logic                  mode;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [ADDR_WIDTH-1:0] tw_addr;
    logic                  out_valid;
    logic [WIDTH-1:0]      a_out;
    logic [WIDTH-1:0]      b_out;

    modport master (
        output in_valid, mode, a, b, tw_addr,
        input  out_valid, a_out, b_out
    );

    modport slave (
        input  in_valid, mode, a, b, tw_addr,
        output out_valid, a_out, b_out
    );
endinterface

// File: rtl/intt_lane.sv
// One registered inverse-NTT lane: Gentleman-Sande butterfly with an
// elaboration-time inverse twiddle ROM, or scaling of both operands by N^-1.
module intt_lane #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned Q              = 8380417,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned N_INV          = 8347681,
    parameter int unsigned PSI            = 1753,
    parameter int unsigned REDUCTION_TYPE = 0
) (
    input logic        clk,
    input logic        rst_n,
    intt_lane_if.slave lane
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned K     = $clog2(Q);

    function automatic logic [63:0] pow_mod(input logic [63:0] base, input logic [63:0] e);
        logic [63:0] r;
        logic [63:0] bb;
        r  = 64'd1;
        bb = base % 64'(Q);
        for (int k = 0; k < 64; k++) begin
            if (e[k]) r = (r * bb) % 64'(Q);
            bb = (bb * bb) % 64'(Q);
        end
        return r;
    endfunction

    // Montgomery mode keeps constant operands pre-scaled by R = 2^WIDTH so a
    // single REDC lands the product back in the normal domain.
    function automatic logic [63:0] to_dom(input logic [63:0] v);
        logic [63:0] r_mod_q;
        r_mod_q = (64'd1 << WIDTH) % 64'(Q);
        return (REDUCTION_TYPE == 2) ? (v * r_mod_q) % 64'(Q) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_q_inv();
        logic [63:0] inv;
        inv = 64'd1;
        for (int k = 0; k < 6; k++) inv = inv * (64'd2 - 64'(Q) * inv);
        return WIDTH'(64'd0 - inv);
    endfunction

    localparam logic [63:0]      PSI_INV = pow_mod(64'(PSI), 64'(Q - 2));
    localparam logic [WIDTH-1:0] N_INV_D = WIDTH'(to_dom(64'(N_INV)));
    localparam logic [WIDTH-1:0] Q_PRIME = neg_q_inv();
    localparam logic [PW-1:0]    MU      = PW'((64'd1 << (2 * K)) / 64'(Q));

    logic [WIDTH-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [63:0] TW = to_dom(pow_mod(PSI_INV, 64'(i)));
        assign rom[i] = WIDTH'(TW);
    end

    function automatic logic [WIDTH-1:0] mod_mult(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [PW-1:0]   p;
        logic [2*PW-1:0] bprod;
        logic [PW-1:0]   qe;
        logic [PW-1:0]   r;
        logic [WIDTH-1:0] m;
        logic [PW:0]     t_sum;
        p     = PW'(x) * PW'(y);
        bprod = '0;
        qe    = '0;
        m     = '0;
        t_sum = '0;
        if (REDUCTION_TYPE == 1) begin
            // Barrett estimate is at most two short, so two conditional subtracts.
            bprod = (2*PW)'(p >> (K - 1)) * (2*PW)'(MU);
            qe    = PW'(bprod >> (K + 1));
            r     = p - qe * PW'(Q);
            if (r >= PW'(Q)) r = r - PW'(Q);
            if (r >= PW'(Q)) r = r - PW'(Q);
        end else if (REDUCTION_TYPE == 2) begin
            m     = WIDTH'(p) * Q_PRIME;
            t_sum = (PW+1)'(p) + (PW+1)'(m) * (PW+1)'(Q);
            r     = PW'(t_sum >> WIDTH);
            if (r >= PW'(Q)) r = r - PW'(Q);
        end else begin
            r = p % PW'(Q);
        end
        return WIDTH'(r);
    endfunction

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] a_out_d, a_out_q;
    logic [WIDTH-1:0] b_out_d, b_out_q;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mul_x, mul_y;

    // One multiplier serves b_out in both modes; a_out needs its own only for scaling.
    always_comb begin
        sum_w = {1'b0, lane.a} + {1'b0, lane.b};
        if (sum_w >= (WIDTH+1)'(Q)) sum_w = sum_w - (WIDTH+1)'(Q);
        diff = lane.a - lane.b;
        if (lane.a < lane.b) diff = diff + WIDTH'(Q);
        mul_x = lane.mode ? lane.b  : diff;
        mul_y = lane.mode ? N_INV_D : rom[lane.tw_addr];

        out_valid_d = lane.in_valid;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        if (lane.in_valid) begin
            a_out_d = lane.mode ? mod_mult(lane.a, N_INV_D) : WIDTH'(sum_w);
            b_out_d = mod_mult(mul_x, mul_y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
        end
    end

    assign lane.out_valid = out_valid_q;
    assign lane.a_out     = a_out_q;
    assign lane.b_out     = b_out_q;
endmodule

// File: tb/tb_intt_lane.sv
// Directed bench for intt_lane: three lanes (one per reduction structure)
// driven identically and each compared against the same expected values.
module tb_intt_lane;
    localparam int unsigned W     = 32;
    localparam int unsigned Q     = 8380417;
    localparam int unsigned PSI   = 1753;
    localparam int unsigned N_INV = 8347681;

    logic clk;
    logic rst_n;

    intt_lane_if #(.WIDTH(W), .ADDR_WIDTH(8)) if0 ();
    intt_lane_if #(.WIDTH(W), .ADDR_WIDTH(8)) if1 ();
    intt_lane_if #(.WIDTH(W), .ADDR_WIDTH(8)) if2 ();

    intt_lane #(.WIDTH(W), .Q(Q), .ADDR_WIDTH(8), .N_INV(N_INV), .PSI(PSI), .REDUCTION_TYPE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .lane(if0));
    intt_lane #(.WIDTH(W), .Q(Q), .ADDR_WIDTH(8), .N_INV(N_INV), .PSI(PSI), .REDUCTION_TYPE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .lane(if1));
    intt_lane #(.WIDTH(W), .Q(Q), .ADDR_WIDTH(8), .N_INV(N_INV), .PSI(PSI), .REDUCTION_TYPE(2))
        dut2 (.clk(clk), .rst_n(rst_n), .lane(if2));

    logic         ov [3];
    logic [W-1:0] ao [3];
    logic [W-1:0] bo [3];
    assign ov[0] = if0.out_valid;
    assign ov[1] = if1.out_valid;
    assign ov[2] = if2.out_valid;
    assign ao[0] = if0.a_out;
    assign ao[1] = if1.a_out;
    assign ao[2] = if2.a_out;
    assign bo[0] = if0.b_out;
    assign bo[1] = if1.b_out;
    assign bo[2] = if2.b_out;

    int           checks;
    int           errors;
    logic [W-1:0] last_a;
    logic [W-1:0] last_b;

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev,
                             input logic [W-1:0] ea, input logic [W-1:0] eb);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_vld_r%0d", tag, k), W'(ov[k]), W'(ev));
            check($sformatf("%s_a_r%0d", tag, k), ao[k], ea);
            check($sformatf("%s_b_r%0d", tag, k), bo[k], eb);
        end
    endtask

    task automatic set_in(input logic v, input logic m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [7:0] ad);
        if0.in_valid = v; if0.mode = m; if0.a = a; if0.b = b; if0.tw_addr = ad;
        if1.in_valid = v; if1.mode = m; if1.a = a; if1.b = b; if1.tw_addr = ad;
        if2.in_valid = v; if2.mode = m; if2.a = a; if2.b = b; if2.tw_addr = ad;
    endtask

    task automatic drive(input logic v, input logic m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [7:0] ad);
        @(negedge clk);
        set_in(v, m, a, b, ad);
    endtask

    // Apply one operation, then check it one edge later (held data if idle).
    task automatic op(input string tag, input logic v, input logic m,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] ad,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
        drive(v, m, a, b, ad);
        @(posedge clk);
        #1;
        if (v) begin
            check_all(tag, 1'b1, ea, eb);
            last_a = ea;
            last_b = eb;
        end else begin
            check_all(tag, 1'b0, last_a, last_b);
        end
    endtask

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y);
        return W'((64'(x) * 64'(y)) % 64'(Q));
    endfunction

    // PSI^-i is PSI^(512-i) because PSI has order 512.
    function automatic logic [W-1:0] psi_pow(input int e);
        logic [W-1:0] r;
        r = 1;
        for (int i = 0; i < e; i++) r = mulmod(r, PSI);
        return r;
    endfunction

    task automatic model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [7:0] ad, output logic [W-1:0] ea, output logic [W-1:0] eb);
        logic [W:0]   s;
        logic [W-1:0] d;
        if (m) begin
            ea = mulmod(a, N_INV);
            eb = mulmod(b, N_INV);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
            d = (a >= b) ? a - b : a + Q - b;
            ea = W'(s);
            eb = mulmod(d, psi_pow(512 - int'(ad)));
        end
    endtask

    initial begin
        logic [W-1:0] pw;
        logic [W-1:0] ra, rb, ea, eb;
        logic [7:0]   rad;
        logic         rm;
        checks = 0;
        errors = 0;
        last_a = '0;
        last_b = '0;
        rst_n  = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, '0);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // latency: nothing visible before the sampling edge
        drive(1'b1, 1'b0, 5, 3, 0);
        #1;
        check_all("pre_edge", 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check_all("bf_5_3", 1'b1, 8, 2);
        last_a = 8;
        last_b = 2;

        op("bf_3_5",   1'b1, 1'b0, 3, 5, 0, 8, 8380415);
        op("bf_max",   1'b1, 1'b0, Q - 1, Q - 1, 0, 8380415, 0);
        op("tw1",      1'b1, 1'b0, 1753, 0, 1, 1753, 1);
        op("sc_256_1", 1'b1, 1'b1, 256, 1, 0, 1, 8347681);
        op("sc_0_max", 1'b1, 1'b1, 0, Q - 1, 0, 0, 32736);
        op("idle",     1'b0, 1'b0, 77, 99, 3, 0, 0);

        pw = 1;
        for (int i = 0; i < 256; i++) begin
            op($sformatf("sweep%0d", i), 1'b1, 1'b0, pw, 0, 8'(i), pw, 1);
            pw = mulmod(pw, PSI);
        end

        for (int i = 0; i < 16; i++) begin
            rm  = ((i % 2) == 1);
            ra  = $urandom_range(Q - 1, 0);
            rb  = $urandom_range(Q - 1, 0);
            rad = 8'($urandom_range(255, 0));
            model(rm, ra, rb, rad, ea, eb);
            op($sformatf("stream%0d", i), 1'b1, rm, ra, rb, rad, ea, eb);
        end
        op("stream_idle", 1'b0, 1'b1, 12345, 54321, 9, 0, 0);

        for (int i = 0; i < 32; i++) begin
            rm  = 1'($urandom_range(1, 0));
            ra  = $urandom_range(Q - 1, 0);
            rb  = $urandom_range(Q - 1, 0);
            rad = 8'($urandom_range(255, 0));
            model(rm, ra, rb, rad, ea, eb);
            op($sformatf("rand%0d", i), 1'b1, rm, ra, rb, rad, ea, eb);
        end

        // asynchronous reset in the middle of an operation
        op("pre_rst", 1'b1, 1'b0, 5, 3, 0, 8, 2);
        drive(1'b1, 1'b0, 10, 20, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check_all("rst_discard", 1'b0, '0, '0);
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        check_all("post_rst_idle", 1'b0, '0, '0);
        op("post_rst_first", 1'b1, 1'b1, 256, 1, 0, 1, 8347681);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/intt_lane.md
# intt_lane

Single registered inverse-NTT processing lane for the N=256, Q=8380417 (Dilithium) inverse transform datapath. Each cycle it takes one coefficient pair, a twiddle index and a mode. It either performs a Gentleman-Sande inverse butterfly with an internally looked-up inverse twiddle, or scales both coefficients by N^(-1). Several lanes are instantiated side by side under the INTT controller/memory; this block holds no coefficient storage.

## Interface
Parameters:
- WIDTH, 32, coefficient width; requires Q < 2^(WIDTH-1)
- Q, 8380417, prime modulus
- ADDR_WIDTH, 8, twiddle index width (log2 N)
- N_INV, 8347681, N^(-1) mod Q (256·8347681 ≡ 1 mod Q)
- PSI, 1753, primitive 2N-th (512th) root of unity mod Q
- REDUCTION_TYPE, 0, reduction structure: 0 = simple `%`, 1 = Barrett, 2 = Montgomery with internal domain correction. All values must produce identical canonical results.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input operands valid this cycle
- mode  in  1  0 = inverse butterfly, 1 = scale
- a  in  WIDTH  first coefficient, range [0,Q)
- b  in  WIDTH  second coefficient, range [0,Q)
- tw_addr  in  ADDR_WIDTH  inverse twiddle index, ignored in scale mode
- out_valid  out  1  results valid
- a_out  out  WIDTH  first result, range [0,Q)
- b_out  out  WIDTH  second result, range [0,Q)

## Operation
- Inverse twiddle ROM: 2^ADDR_WIDTH entries, combinational lookup.
  - ROM[i] = PSI^(-i) mod Q, i.e. ROM[i]·PSI^i ≡ 1 mod Q.
  - ROM[0] = 1.
  - ROM contents are computed at elaboration with a constant function; no hand-typed tables. The surrounding controller supplies bit-reversed indices.
- mod_mult(x,y): full 2·WIDTH-bit product reduced to canonical [0,Q).
- Butterfly mode (mode=0):
  - s = a+b, computed in WIDTH+1 bits. If s ≥ Q, subtract Q.
  - d = a−b. If a < b, d = a−b+Q.
  - a_out = s.
  - b_out = mod_mult(d, ROM[tw_addr]).
- Scale mode (mode=1): a_out = mod_mult(a, N_INV); b_out = mod_mult(b, N_INV).
- Operands ≥ Q are outside the contract. For such inputs, data outputs are don't-care, but out_valid timing is unaffected.
- No internal state beyond the output register; no stall or backpressure input.

## Timing
- Latency is exactly 1 cycle: operands sampled at edge k appear on a_out/b_out at edge k with out_valid=1. The datapath is combinational from the inputs into the output register.
- Throughput: one operation per cycle; back-to-back in_valid is fully supported and mode may change every cycle.
- out_valid <= in_valid every cycle.
- a_out/b_out update only when in_valid=1 and hold their previous value otherwise.
- Reset values: out_valid=0, a_out=0, b_out=0.
  - Assertion is immediate, asynchronous to clk.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid output after deassertion corresponds to the first in_valid sampled after deassertion.

## Test plan
- Reset: assert rst_n=0 between clock edges -> out_valid, a_out, b_out become 0 immediately without waiting for an edge.
- Butterfly with identity twiddle: mode=0, tw_addr=0.
  - a=5, b=3 -> a_out=8, b_out=2.
  - a=3, b=5 -> a_out=8, b_out=8380415.
  - a=b=8380416 -> a_out=8380415, b_out=0.
  - Each result appears exactly 1 cycle after its input.
- Twiddle ROM: mode=0, tw_addr=1, a=1753, b=0 -> a_out=1753, b_out=1. Sweep all 256 indices with a=PSI^i mod Q, b=0 -> b_out=1 for every i.
- Scale: mode=1.
  - a=256, b=1 -> a_out=1, b_out=8347681.
  - a=0, b=8380416 -> a_out=0, b_out=Q−8347681=32736.
- Streaming: 16 consecutive in_valid cycles with alternating mode and random canonical operands -> 16 consecutive out_valid cycles matching a software model. Then in_valid=0 -> out_valid=0 with data held.
- REDUCTION_TYPE 0/1/2 instances driven with the same random vectors -> bit-identical outputs.
